// File: rtl/mem_port_arbiter_if.sv
// Bundle of load/store requester handshakes and the BRAM-facing memory port
// shared by mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_LD     = 2,
  parameter int NUM_ST     = 2
);
  logic [NUM_LD*ADDR_WIDTH-1:0] ld_addr;
  logic [NUM_LD-1:0]            ld_addr_valid;
  logic [NUM_LD-1:0]            ld_addr_ready;
  logic [NUM_LD*DATA_WIDTH-1:0] ld_data;
  logic [NUM_LD-1:0]            ld_data_valid;
  logic [NUM_LD-1:0]            ld_data_ready;

  logic [NUM_ST*ADDR_WIDTH-1:0] st_addr;
  logic [NUM_ST*DATA_WIDTH-1:0] st_data;
  logic [NUM_ST-1:0]            st_valid;
  logic [NUM_ST-1:0]            st_ready;

  logic                         loadEn;
  logic [ADDR_WIDTH-1:0]        loadAddr;
  logic [DATA_WIDTH-1:0]        loadData;
  logic                         storeEn;
  logic [ADDR_WIDTH-1:0]        storeAddr;
  logic [DATA_WIDTH-1:0]        storeData;

  modport slave (
    input  ld_addr, ld_addr_valid, ld_data_ready,
    output ld_addr_ready, ld_data, ld_data_valid,
    input  st_addr, st_data, st_valid,
    output st_ready,
    output loadEn, loadAddr, storeEn, storeAddr, storeData,
    input  loadData
  );

  modport master (
    output ld_addr, ld_addr_valid, ld_data_ready,
    input  ld_addr_ready, ld_data, ld_data_valid,
    output st_addr, st_data, st_valid,
    input  st_ready,
    input  loadEn, loadAddr, storeEn, storeAddr, storeData,
    output loadData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one read/write BRAM port among load and store
// requesters; each load requester owns a 1-entry result buffer.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_LD     = 2,
  parameter int NUM_ST     = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int LDW = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;
  localparam int STW = (NUM_ST > 1) ? $clog2(NUM_ST) : 1;
  localparam int unsigned NLD = NUM_LD;
  localparam int unsigned NST = NUM_ST;

  logic [LDW-1:0]                   r_ld_ptr;
  logic [LDW-1:0]                   r_ld_id;
  logic                             r_inflight;
  logic [NUM_LD-1:0]                r_buf_valid;
  logic [NUM_LD-1:0][DATA_WIDTH-1:0] r_buf;
  logic [STW-1:0]                   r_st_ptr;

  logic [NUM_LD-1:0]                w_ld_elig;
  logic                             w_ld_found;
  logic [LDW-1:0]                   w_ld_sel;
  logic                             w_st_found;
  logic [STW-1:0]                   w_st_sel;

  always_comb begin : ld_arb
    logic [LDW-1:0] idx;
    idx = '0;
    w_ld_elig = '0;
    for (int unsigned i = 0; i < NLD; i++) begin
      w_ld_elig[i] = bus.ld_addr_valid[i] && !r_buf_valid[i] &&
                     !(r_inflight && (32'(r_ld_id) == i));
    end
    w_ld_found = 1'b0;
    w_ld_sel   = '0;
    for (int unsigned k = 1; k <= NLD; k++) begin
      idx = LDW'((32'(r_ld_ptr) + k) % NLD);
      if (!w_ld_found && w_ld_elig[idx]) begin
        w_ld_found = 1'b1;
        w_ld_sel   = idx;
      end
    end
  end

  always_comb begin : st_arb
    logic [STW-1:0] idx;
    idx = '0;
    w_st_found = 1'b0;
    w_st_sel   = '0;
    for (int unsigned k = 1; k <= NST; k++) begin
      idx = STW'((32'(r_st_ptr) + k) % NST);
      if (!w_st_found && bus.st_valid[idx]) begin
        w_st_found = 1'b1;
        w_st_sel   = idx;
      end
    end
  end

  always_comb begin
    bus.ld_addr_ready = '0;
    bus.loadEn        = w_ld_found;
    bus.loadAddr      = '0;
    if (w_ld_found) begin
      bus.ld_addr_ready[w_ld_sel] = 1'b1;
      bus.loadAddr = bus.ld_addr[32'(w_ld_sel)*ADDR_WIDTH +: ADDR_WIDTH];
    end
    bus.st_ready  = '0;
    bus.storeEn   = w_st_found;
    bus.storeAddr = '0;
    bus.storeData = '0;
    if (w_st_found) begin
      bus.st_ready[w_st_sel] = 1'b1;
      bus.storeAddr = bus.st_addr[32'(w_st_sel)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.storeData = bus.st_data[32'(w_st_sel)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.ld_data       = r_buf;
  assign bus.ld_data_valid = r_buf_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_ptr    <= LDW'(NUM_LD - 1);
      r_st_ptr    <= STW'(NUM_ST - 1);
      r_inflight  <= 1'b0;
      r_ld_id     <= '0;
      r_buf_valid <= '0;
      r_buf       <= '0;
    end else begin
      if (w_ld_found) begin
        r_ld_ptr <= w_ld_sel;
        r_ld_id  <= w_ld_sel;
      end
      if (w_st_found) r_st_ptr <= w_st_sel;
      r_inflight  <= w_ld_found;
      r_buf_valid <= r_buf_valid & ~bus.ld_data_ready;
      // Capture target is never the buffer being drained: it was empty at grant.
      if (r_inflight) begin
        r_buf_valid[r_ld_id] <= 1'b1;
        r_buf[r_ld_id]       <= bus.loadData;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a read-first BRAM
// model and a per-requester outstanding-load reference model.
module tb_mem_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int NL = 2;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LD(NL), .NUM_ST(NS)) bus ();

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LD(NL), .NUM_ST(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] bram [0:(1<<AW)-1];
  logic [DW-1:0] r_rd = '0;
  always @(posedge clk) begin
    if (bus.loadEn)  r_rd <= bram[bus.loadAddr];
    if (bus.storeEn) bram[bus.storeAddr] <= bus.storeData;
  end
  assign bus.loadData = r_rd;

  // Reference model: memory image, per-requester load status
  // (0 idle, 1 read in flight, 2 result held), round-robin last winners.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_state [NL];
  int            m_ld_last;
  int            m_st_last;
  logic [DW-1:0] exp_q [NL][$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_state[i] = 0;
      exp_q[i].delete();
    end
    m_ld_last = NL - 1;
    m_st_last = NS - 1;
  endtask

  task automatic zero_inputs();
    bus.ld_addr_valid = '0;
    bus.ld_addr       = '0;
    bus.ld_data_ready = '0;
    bus.st_valid      = '0;
    bus.st_addr       = '0;
    bus.st_data       = '0;
  endtask

  task automatic cycle(input logic [NL-1:0] lv, input logic [AW-1:0] la0, input logic [AW-1:0] la1,
                       input logic [NL-1:0] lr, input logic [NS-1:0] sv,
                       input logic [AW-1:0] sa0, input logic [AW-1:0] sa1,
                       input logic [DW-1:0] sd0, input logic [DW-1:0] sd1);
    logic [AW-1:0] la [NL];
    logic [AW-1:0] sa [NS];
    logic [DW-1:0] sd [NS];
    logic [NL-1:0] exp_rdy;
    logic [NL-1:0] exp_v;
    logic [NS-1:0] exp_sr;
    int g;
    int sg;
    int idx;
    la[0] = la0; la[1] = la1;
    sa[0] = sa0; sa[1] = sa1;
    sd[0] = sd0; sd[1] = sd1;
    @(negedge clk);
    bus.ld_addr_valid = lv;
    bus.ld_addr       = {la1, la0};
    bus.ld_data_ready = lr;
    bus.st_valid      = sv;
    bus.st_addr       = {sa1, sa0};
    bus.st_data       = {sd1, sd0};
    #1;
    g = -1;
    for (int k = 1; k <= NL; k++) begin
      idx = (m_ld_last + k) % NL;
      if (g < 0 && lv[idx] && m_state[idx] == 0) g = idx;
    end
    sg = -1;
    for (int k = 1; k <= NS; k++) begin
      idx = (m_st_last + k) % NS;
      if (sg < 0 && sv[idx]) sg = idx;
    end
    exp_rdy = '0;
    exp_sr  = '0;
    if (g >= 0)  exp_rdy[g] = 1'b1;
    if (sg >= 0) exp_sr[sg] = 1'b1;
    for (int i = 0; i < NL; i++) exp_v[i] = (m_state[i] == 2);

    chk("ld_data_valid", 32'(bus.ld_data_valid), 32'(exp_v));
    chk("ld_addr_ready", 32'(bus.ld_addr_ready), 32'(exp_rdy));
    chk("loadEn",        32'(bus.loadEn), 32'(g >= 0));
    chk("loadAddr",      32'(bus.loadAddr), (g >= 0) ? 32'(la[g]) : 32'd0);
    chk("st_ready",      32'(bus.st_ready), 32'(exp_sr));
    chk("storeEn",       32'(bus.storeEn), 32'(sg >= 0));
    chk("storeAddr",     32'(bus.storeAddr), (sg >= 0) ? 32'(sa[sg]) : 32'd0);
    chk("storeData",     32'(bus.storeData), (sg >= 0) ? 32'(sd[sg]) : 32'd0);

    for (int i = 0; i < NL; i++) begin
      if (m_state[i] == 1) m_state[i] = 2;
      else if (m_state[i] == 2 && lr[i]) m_state[i] = 0;
    end
    if (g >= 0) begin
      exp_q[g].push_back(ref_mem[la[g]]);
      m_state[g] = 1;
      m_ld_last  = g;
    end
    if (sg >= 0) begin
      ref_mem[sa[sg]] = sd[sg];
      m_st_last = sg;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    zero_inputs();
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_ld_data_valid", 32'(bus.ld_data_valid), 32'd0);
    chk("reset_ld_data",       32'(bus.ld_data), 32'd0);
    chk("reset_loadEn",        32'(bus.loadEn), 32'd0);
    chk("reset_storeEn",       32'(bus.storeEn), 32'd0);
    rst = 1'b1;
  endtask

  // Monitor: every result handshake pops and checks the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        for (int i = 0; i < NL; i++) begin
          if (bus.ld_data_valid[i] && bus.ld_data_ready[i]) begin
            if (exp_q[i].size() == 0)
              chk("ld_result_expected", 32'(exp_q[i].size()), 32'd1);
            else
              chk("ld_data", 32'(bus.ld_data[i*DW +: DW]), 32'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    zero_inputs();
    for (int i = 0; i < (1 << AW); i++) begin
      bram[i]    = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end
    bram[5] = 8'h3C; ref_mem[5] = 8'h3C;
    bram[9] = 8'h11; ref_mem[9] = 8'h11;
    model_reset();
    do_reset();

    // Two stores contending: st0 first, then st1.
    cycle(2'b00, 0, 0, 2'b11, 2'b11, 7'd3, 7'd4, 8'hAA, 8'h55);
    cycle(2'b00, 0, 0, 2'b11, 2'b10, 7'd3, 7'd4, 8'hAA, 8'h55);
    cycle(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);

    // Single load of address 5.
    cycle(2'b01, 7'd5, 0, 2'b11, 2'b00, 0, 0, 0, 0);
    repeat (3) cycle(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);

    // Same-address load and store, then a later load sees the new value.
    cycle(2'b01, 7'd9, 0, 2'b11, 2'b01, 7'd9, 0, 8'h77, 0);
    repeat (3) cycle(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);
    cycle(2'b10, 0, 7'd9, 2'b11, 2'b00, 0, 0, 0, 0);
    repeat (3) cycle(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);

    // Back-pressure on requester 0 while requester 1 keeps loading.
    repeat (8) cycle(2'b11, 7'd20, 7'd21, 2'b10, 2'b00, 0, 0, 0, 0);
    repeat (3) cycle(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);

    // Both loads continuously valid and drained.
    repeat (9) cycle(2'b11, 7'd30, 7'd31, 2'b11, 2'b00, 0, 0, 0, 0);
    repeat (3) cycle(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);

    // Reset in the cycle after a grant: the in-flight read must vanish.
    cycle(2'b10, 0, 7'd40, 2'b11, 2'b00, 0, 0, 0, 0);
    cycle(2'b01, 7'd41, 0, 2'b11, 2'b00, 0, 0, 0, 0);
    do_reset();
    repeat (2) cycle(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);
    cycle(2'b11, 7'd42, 7'd43, 2'b11, 2'b11, 7'd44, 7'd45, 8'h01, 8'h02);
    chk("post_reset_ld_winner", 32'(bus.ld_addr_ready), 32'd1);
    chk("post_reset_st_winner", 32'(bus.st_ready), 32'd1);
    repeat (3) cycle(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      cycle(NL'($urandom), AW'($urandom), AW'($urandom),
            {($urandom % 4) != 0, ($urandom % 4) != 0},
            NS'($urandom), AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
    end

    repeat (6) cycle(2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < NL; i++) chk("scoreboard_empty", 32'(exp_q[i].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
